// File: rtl/ram_arbiter.sv
// ----------------------------------------------------------------------------
// ram_arbiter
//
// Shares one single-port synchronous RAM (default 16x8) between the CPU
// control path and an external loader/debug port. Each access takes three
// cycles:
//   IDLE -> GRANT_x -> DONE_x -> IDLE
// The requester sees its ack pulse in the cycle after DONE_x. That cycle is
// an IDLE cycle, so a requester that keeps req high through its ack gets its
// next access started immediately. Read data is captured from the RAM at the
// end of DONE_x and so appears together with the ack.
//
// Optional build macro RAM_ARB_RR_EN:
//   defined   - ties go to whichever port was not the last owner
//               (round robin); the starvation counter is held at zero.
//   undefined - the CPU wins ties until the loader has lost STARVE_LIMIT
//               ties in a row; the loader then wins one tie.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cpu_req/we/addr/wdata        CPU request, held until cpu_ack
//   cpu_ack, cpu_rdata           completion pulse, read data (held)
//   cpu_stall                    cpu_req & ~cpu_ack (combinational)
//   ext_req/we/addr/wdata        loader request, held until ext_ack
//   ext_ack, ext_rdata           completion pulse, read data (held)
//   ram_ce_n, ram_we_n           RAM strobes, active-low
//   ram_addr, ram_wdata          RAM address / write data
//   ram_rdata                    RAM read data, one-cycle latency
// ----------------------------------------------------------------------------
module ram_arbiter #(
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_ack,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ram_ce_n,
    output logic              ram_we_n,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        GRANT_CPU,
        GRANT_EXT,
        DONE_CPU,
        DONE_EXT
    } state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_EXT = 1'b1;

    state_t            state_reg;
    logic [3:0]        starve_cnt_reg;
    logic [3:0]        starve_cnt_next;
    logic              last_owner_reg;
    logic              acc_we_reg;      // direction of the access in flight
    logic              cpu_ack_reg;
    logic              ext_ack_reg;
    logic [DATA_W-1:0] cpu_rdata_reg;
    logic [DATA_W-1:0] ext_rdata_reg;
    logic              ram_ce_n_reg;
    logic              ram_we_n_reg;
    logic [ADDR_W-1:0] ram_addr_reg;
    logic [DATA_W-1:0] ram_wdata_reg;
    logic              grant_cpu;
    logic              grant_ext;

    // Arbitration decision; only acted upon while the FSM is in IDLE.
    always_comb begin
        grant_cpu       = 1'b0;
        grant_ext       = 1'b0;
        starve_cnt_next = '0;
        if (cpu_req && ext_req) begin
`ifdef RAM_ARB_RR_EN
            if (last_owner_reg == OWNER_CPU) begin
                grant_ext = 1'b1;
            end else begin
                grant_cpu = 1'b1;
            end
`else
            if (starve_cnt_reg == 4'(STARVE_LIMIT)) begin
                grant_ext = 1'b1;
            end else begin
                grant_cpu = 1'b1;
                // Saturate so a limit of 15 can never wrap back to zero.
                starve_cnt_next = (starve_cnt_reg == 4'hF) ? starve_cnt_reg
                                                            : starve_cnt_reg + 4'd1;
            end
`endif
        end else if (cpu_req) begin
            grant_cpu = 1'b1;
        end else if (ext_req) begin
            grant_ext = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= '0;
            last_owner_reg <= OWNER_CPU;
            acc_we_reg     <= 1'b0;
            cpu_ack_reg    <= 1'b0;
            ext_ack_reg    <= 1'b0;
            cpu_rdata_reg  <= '0;
            ext_rdata_reg  <= '0;
            ram_ce_n_reg   <= 1'b1;
            ram_we_n_reg   <= 1'b1;
            ram_addr_reg   <= '0;
            ram_wdata_reg  <= '0;
        end else begin
            cpu_ack_reg <= 1'b0;
            ext_ack_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    starve_cnt_reg <= starve_cnt_next;
                    if (grant_cpu) begin
                        state_reg      <= GRANT_CPU;
                        last_owner_reg <= OWNER_CPU;
                        acc_we_reg     <= cpu_we;
                        ram_ce_n_reg   <= 1'b0;
                        ram_we_n_reg   <= ~cpu_we;
                        ram_addr_reg   <= cpu_addr;
                        ram_wdata_reg  <= cpu_wdata;
                    end else if (grant_ext) begin
                        state_reg      <= GRANT_EXT;
                        last_owner_reg <= OWNER_EXT;
                        acc_we_reg     <= ext_we;
                        ram_ce_n_reg   <= 1'b0;
                        ram_we_n_reg   <= ~ext_we;
                        ram_addr_reg   <= ext_addr;
                        ram_wdata_reg  <= ext_wdata;
                    end
                end
                GRANT_CPU: begin
                    state_reg    <= DONE_CPU;
                    ram_ce_n_reg <= 1'b1;
                    ram_we_n_reg <= 1'b1;
                end
                GRANT_EXT: begin
                    state_reg    <= DONE_EXT;
                    ram_ce_n_reg <= 1'b1;
                    ram_we_n_reg <= 1'b1;
                end
                DONE_CPU: begin
                    state_reg   <= IDLE;
                    cpu_ack_reg <= 1'b1;
                    if (!acc_we_reg) begin
                        cpu_rdata_reg <= ram_rdata;
                    end
                end
                DONE_EXT: begin
                    state_reg   <= IDLE;
                    ext_ack_reg <= 1'b1;
                    if (!acc_we_reg) begin
                        ext_rdata_reg <= ram_rdata;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign cpu_ack   = cpu_ack_reg;
    assign ext_ack   = ext_ack_reg;
    assign cpu_rdata = cpu_rdata_reg;
    assign ext_rdata = ext_rdata_reg;
    assign ram_ce_n  = ram_ce_n_reg;
    assign ram_we_n  = ram_we_n_reg;
    assign ram_addr  = ram_addr_reg;
    assign ram_wdata = ram_wdata_reg;
    assign cpu_stall = cpu_req & ~cpu_ack_reg;

endmodule

// File: tb/tb_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_arbiter
//
// Directed bench for ram_arbiter with a behavioural 16x8 synchronous RAM.
// Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_req, cpu_we;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_ack;
    logic [7:0] cpu_rdata;
    logic       cpu_stall;
    logic       ext_req, ext_we;
    logic [3:0] ext_addr;
    logic [7:0] ext_wdata;
    logic       ext_ack;
    logic [7:0] ext_rdata;
    logic       ram_ce_n, ram_we_n;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata = 8'h00;
    logic [7:0] mem [16] = '{default: 8'h00};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM model: one-cycle read latency.
    always @(posedge clk) begin
        if (!ram_ce_n) begin
            if (!ram_we_n) mem[ram_addr] <= ram_wdata;
            else           ram_rdata     <= mem[ram_addr];
        end
    end

    ram_arbiter #(.ADDR_W(4), .DATA_W(8), .STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .ext_req   (ext_req),
        .ext_we    (ext_we),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_ack   (ext_ack),
        .ext_rdata (ext_rdata),
        .ram_ce_n  (ram_ce_n),
        .ram_we_n  (ram_we_n),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One complete access on one port; called and returns on a falling edge.
    task automatic access(input bit is_ext, input bit we, input logic [3:0] addr,
                          input logic [7:0] wd, input logic [7:0] exp_rd);
        int lat = 0, ce_low = 0, we_low = 0, stall_cnt = 0, other = 0;
        bit got = 1'b0;
        if (is_ext) begin
            ext_req = 1'b1; ext_we = we; ext_addr = addr; ext_wdata = wd;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        end
        #1;
        if (cpu_stall) stall_cnt++;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if (!ram_ce_n) ce_low++;
            if (!ram_we_n) we_low++;
            if (cpu_stall) stall_cnt++;
            if (is_ext ? cpu_ack : ext_ack) other++;
            got = is_ext ? ext_ack : cpu_ack;
        end
        chk("ack_latency", lat, 3);
        chk("rdata", is_ext ? ext_rdata : cpu_rdata, exp_rd);
        chk("ce_low_cycles", ce_low, 1);
        chk("we_low_cycles", we_low, we ? 1 : 0);
        chk("stall_cycles", stall_cnt, is_ext ? 0 : 3);
        chk("other_port_ack", other, 0);
        chk("ram_addr_held", ram_addr, addr);
        if (we) chk("ram_wdata_held", ram_wdata, wd);
        $display("%s %s addr=%0h wdata=%0h rdata=%0h latency=%0d",
                 is_ext ? "EXT" : "CPU", we ? "WR" : "RD", addr, wd,
                 is_ext ? ext_rdata : cpu_rdata, lat);
        if (is_ext) ext_req = 1'b0; else cpu_req = 1'b0;
        @(negedge clk);
        chk("no_regrant_ce", ram_ce_n, 1'b1);
        chk("ack_single_pulse", is_ext ? ext_ack : cpu_ack, 1'b0);
    endtask

    typedef struct {
        bit         is_ext;
        bit         we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;   // read data, or held value for a write
    } vec_t;

    vec_t vecs [6];

    initial begin
        bit         exp_ext [10];
        logic [7:0] exp_b;
        int         start, n;
        bit         got;

        vecs[0] = '{1'b0, 1'b1, 4'h3, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 4'h3, 8'h00, 8'hA5};
        vecs[2] = '{1'b1, 1'b1, 4'hF, 8'h5A, 8'h00};
        vecs[3] = '{1'b0, 1'b0, 4'hF, 8'h00, 8'h5A};
        vecs[4] = '{1'b1, 1'b0, 4'h3, 8'h00, 8'hA5};
        vecs[5] = '{1'b1, 1'b0, 4'hF, 8'h00, 8'h5A};
        exp_ext = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_ram_ce_n", ram_ce_n, 1'b1);
        chk("rst_ram_we_n", ram_we_n, 1'b1);
        chk("rst_ram_addr", ram_addr, 4'h0);
        chk("rst_ram_wdata", ram_wdata, 8'h00);
        chk("rst_cpu_ack", cpu_ack, 1'b0);
        chk("rst_ext_ack", ext_ack, 1'b0);
        chk("rst_cpu_rdata", cpu_rdata, 8'h00);
        chk("rst_ext_rdata", ext_rdata, 8'h00);
        chk("rst_cpu_stall", cpu_stall, 1'b0);

        for (int i = 0; i < 6; i++)
            access(vecs[i].is_ext, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);

        // Loader preload: mem[a] = a ^ 8'hFF.
        for (int a = 0; a < 16; a++)
            access(1'b1, 1'b1, 4'(a), 8'(a) ^ 8'hFF, 8'h5A);

        // Back-to-back CPU reads with req held high, address advanced on ack.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h0;
        start = cyc;
        for (int i = 0; i < 16; i++) begin
            n = 0; got = 1'b0;
            while (!got && n < 8) begin
                @(negedge clk);
                n++;
                got = cpu_ack;
                if (ext_ack) chk("b2b_no_ext_ack", ext_ack, 1'b0);
            end
            exp_b = 8'(i) ^ 8'hFF;
            chk("b2b_spacing", n, 3);
            chk("b2b_rdata", cpu_rdata, exp_b);
            $display("CPU RD b2b addr=%0h rdata=%0h spacing=%0d", i, cpu_rdata, n);
            if (i < 15) cpu_addr = 4'(i + 1);
            else        cpu_req  = 1'b0;
        end
        chk("b2b_total_cycles", cyc - start, 48);

        // Both ports requesting continuously.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h1;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 4'h2;
        for (int k = 0; k < 10; k++) begin
            n = 0; got = 1'b0;
            while (!got && n < 8) begin
                @(negedge clk);
                n++;
                got = cpu_ack | ext_ack;
            end
            chk("arb_spacing", n, 3);
            chk("arb_one_ack", {cpu_ack, ext_ack} == 2'b11, 1'b0);
            chk("arb_winner_ext", ext_ack, exp_ext[k]);
            if (ext_ack) chk("arb_ext_rdata", ext_rdata, 8'hFD);
            else         chk("arb_cpu_rdata", cpu_rdata, 8'hFE);
            $display("ARB grant %0d winner=%s", k, ext_ack ? "EXT" : "CPU");
        end
        cpu_req = 1'b0; ext_req = 1'b0;
        @(negedge clk);

        // Reset during GRANT_EXT of a read.
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 4'h5;
        @(negedge clk);
        chk("rstmid_in_grant", ram_ce_n, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_ce_n", ram_ce_n, 1'b1);
        chk("rstmid_ext_ack", ext_ack, 1'b0);
        chk("rstmid_ext_rdata", ext_rdata, 8'h00);
        rst = 1'b0; ext_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rstmid_no_late_ack", ext_ack, 1'b0);
        end
        $display("RST during GRANT_EXT: ext_ack=%0b ext_rdata=%0h", ext_ack, ext_rdata);
        access(1'b1, 1'b0, 4'h5, 8'h00, 8'hFA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
